// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Brief    : Shared types, constants and address-fault helper for mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    // Misaligned, or any address bit above the word index set.
    function automatic logic addr_fault(input logic [31:0] addr, input int idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_array
// Brief    : DEPTH_WORDS x 32 storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    // Deliberately no reset: contents survive a reset of the responder.
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Two-port (instruction/data) wait-state memory responder with
//            IDLE/WAIT/RESP FSM. Define MEM_RESPONDER_RR_ARB_EN for
//            round-robin arbitration; default is fixed data-port priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        busy,
    output logic        err
);

    localparam int               c_idx_w    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] c_cnt_load = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_next_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    port_t             r_port;
    logic [31:0]       r_i_rdata;
    logic [31:0]       r_d_rdata;

    port_t             w_grant;
    logic              w_accept;
    logic [31:0]       w_acc_addr;
    logic              w_acc_we;
    logic [31:0]       w_sel_addr;
    port_t             w_sel_port;
    logic              w_sel_we;
    logic              w_sel_fault;
    logic              w_mem_we;
    logic [31:0]       w_mem_rdata;

`ifdef MEM_RESPONDER_RR_ARB_EN
    port_t r_rr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= PORT_D;
        end else if (w_accept && i_req && d_req) begin
            r_rr_ptr <= (w_grant == PORT_D) ? PORT_I : PORT_D;
        end
    end

    always_comb begin
        w_grant = PORT_D;
        if (i_req && d_req) begin
            w_grant = r_rr_ptr;
        end else if (i_req) begin
            w_grant = PORT_I;
        end
    end
`else
    always_comb begin
        w_grant = PORT_D;
        if (!d_req) begin
            w_grant = PORT_I;
        end
    end
`endif

    assign w_accept   = (r_state == IDLE) && (i_req || d_req);
    assign w_acc_addr = (w_grant == PORT_D) ? d_addr : i_addr;
    assign w_acc_we   = (w_grant == PORT_D) && d_we;

    // With zero wait states the read happens on the accepting edge, before
    // the address is latched, so look at the incoming request while IDLE.
    assign w_sel_addr  = (r_state == IDLE) ? w_acc_addr : r_addr;
    assign w_sel_port  = (r_state == IDLE) ? w_grant    : r_port;
    assign w_sel_we    = (r_state == IDLE) ? w_acc_we   : r_we;
    assign w_sel_fault = addr_fault(w_sel_addr, c_idx_w);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_next_state = WAIT;
                        w_next_cnt   = c_cnt_load;
                    end else begin
                        w_next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_port  <= PORT_D;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr  <= w_acc_addr;
                r_we    <= w_acc_we;
                r_wdata <= d_wdata;
                r_port  <= w_grant;
            end
        end
    end

    // Read data is captured on entry to RESP and held until the port's next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if ((w_next_state == RESP) && !w_sel_we) begin
            if (w_sel_port == PORT_I) begin
                r_i_rdata <= w_sel_fault ? '0 : w_mem_rdata;
            end else begin
                r_d_rdata <= w_sel_fault ? '0 : w_mem_rdata;
            end
        end
    end

    assign w_mem_we = (r_state == RESP) && r_we && !w_sel_fault;

    mem_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_addr[c_idx_w+1:2]),
        .i_wdata (r_wdata),
        .i_raddr (w_sel_addr[c_idx_w+1:2]),
        .o_rdata (w_mem_rdata)
    );

    assign i_ack   = (r_state == RESP) && (r_port == PORT_I);
    assign d_ack   = (r_state == RESP) && (r_port == PORT_D);
    assign err     = (r_state == RESP) && w_sel_fault;
    assign busy    = (r_state != IDLE);
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench; instance A uses WAIT_STATES=2,
//            instance B uses WAIT_STATES=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        reset;

    logic        a_i_req, a_d_req, a_d_we;
    logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
    logic [31:0] a_i_rdata, a_d_rdata;
    logic        a_i_ack, a_d_ack, a_busy, a_err;

    logic        b_i_req, b_d_req, b_d_we;
    logic [31:0] b_i_addr, b_d_addr, b_d_wdata;
    logic [31:0] b_i_rdata, b_d_rdata;
    logic        b_i_ack, b_d_ack, b_busy, b_err;

    int checks = 0;
    int passed = 0;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_ack(a_i_ack),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdata(a_d_rdata), .d_ack(a_d_ack), .busy(a_busy), .err(a_err)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack), .busy(b_busy), .err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One data-port access on instance A; lat counts edges from request to ack.
    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic e, output logic [31:0] rd);
        lat = 0;
        e   = 1'b0;
        rd  = '0;
        a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (a_d_ack) begin
                lat = n; e = a_err; rd = a_d_rdata;
                break;
            end
        end
        a_d_req = 1'b0; a_d_we = 1'b0;
        step();
    endtask

    initial begin
        int          lat, d_cyc, i_cyc, overlap, k, busy_cnt, ack_n, acks;
        logic        e;
        logic [31:0] rd, d_rd, i_rd;
        logic [3:0]  seq;

        reset = 1'b0;
        a_i_req = 0; a_d_req = 0; a_d_we = 0; a_i_addr = '0; a_d_addr = '0; a_d_wdata = '0;
        b_i_req = 0; b_d_req = 0; b_d_we = 0; b_i_addr = '0; b_d_addr = '0; b_d_wdata = '0;
        repeat (2) step();
        check("rst_busy",    a_busy,    0);
        check("rst_i_ack",   a_i_ack,   0);
        check("rst_d_ack",   a_d_ack,   0);
        check("rst_err",     a_err,     0);
        check("rst_i_rdata", a_i_rdata, 0);
        check("rst_d_rdata", a_d_rdata, 0);
        reset = 1'b1;
        step();

        // Write then read back word 0x10.
        d_access(1'b1, 32'h10, 32'hDEADBEEF, lat, e, rd);
        check("wr10_lat", lat, 3);
        check("wr10_err", e,   0);
        d_access(1'b0, 32'h10, 32'h0, lat, e, rd);
        check("rd10_lat",  lat, 3);
        check("rd10_data", rd,  32'hDEADBEEF);
        check("rd10_err",  e,   0);
        repeat (3) step();
        check("rd10_hold", a_d_rdata, 32'hDEADBEEF);

        // Contested request: data first, fetch one full turnaround later.
        d_access(1'b1, 32'h0, 32'h11111111, lat, e, rd);
        a_i_req = 1'b1; a_i_addr = 32'h10;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h0;
        d_cyc = 0; i_cyc = 0; overlap = 0; d_rd = '0; i_rd = '0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (a_i_ack && a_d_ack) overlap++;
            if (a_d_ack && d_cyc == 0) begin d_cyc = n; d_rd = a_d_rdata; a_d_req = 1'b0; end
            if (a_i_ack && i_cyc == 0) begin i_cyc = n; i_rd = a_i_rdata; a_i_req = 1'b0; end
            if (i_cyc != 0) break;
        end
        a_i_req = 1'b0; a_d_req = 1'b0;
        step();
        check("arb_d_cyc",   d_cyc,   3);
        check("arb_i_cyc",   i_cyc,   7);
        check("arb_overlap", overlap, 0);
        check("arb_d_rdata", d_rd,    32'h11111111);
        check("arb_i_rdata", i_rd,    32'hDEADBEEF);

        // Faulting accesses: misaligned and out of range.
        d_access(1'b1, 32'h13, 32'hBAD0BAD0, lat, e, rd);
        check("f13_lat", lat, 3);
        check("f13_err", e,   1);
        d_access(1'b0, 32'h10, 32'h0, lat, e, rd);
        check("f13_keep", rd, 32'hDEADBEEF);
        check("f13_rderr", e, 0);
        d_access(1'b1, 32'h1000, 32'hCAFEF00D, lat, e, rd);
        check("f1000_err", e, 1);
        d_access(1'b0, 32'h0, 32'h0, lat, e, rd);
        check("f1000_keep", rd, 32'h11111111);
        d_access(1'b0, 32'h1000, 32'h0, lat, e, rd);
        check("frd_data", rd, 0);
        check("frd_err",  e,  1);
        check("idle_err", a_err, 0);

        // Reset during WAIT of a write aborts it.
        d_access(1'b1, 32'h20, 32'h22222222, lat, e, rd);
        d_access(1'b0, 32'h10, 32'h0, lat, e, rd);
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h20; a_d_wdata = 32'h99999999;
        step();
        check("abort_busy_pre", a_busy, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy",    a_busy,    0);
        check("abort_d_ack",   a_d_ack,   0);
        check("abort_d_rdata", a_d_rdata, 0);
        check("abort_i_rdata", a_i_rdata, 0);
        a_d_req = 1'b0; a_d_we = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        acks = 0;
        for (int n = 1; n <= 6; n++) begin
            step();
            if (a_d_ack || a_i_ack) acks++;
        end
        check("abort_noack", acks, 0);
        d_access(1'b0, 32'h20, 32'h0, lat, e, rd);
        check("abort_keep", rd, 32'h22222222);

        // Reset first so the round-robin pointer starts on d.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        a_i_req = 1'b1; a_i_addr = 32'h10;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h0;
        k = 0; seq = '0;
        for (int n = 1; n <= 80; n++) begin
            step();
            if (a_d_ack) begin seq[k] = 1'b1; k++; end
            else if (a_i_ack) begin seq[k] = 1'b0; k++; end
            if (k == 4) break;
        end
        a_i_req = 1'b0; a_d_req = 1'b0;
        step();
        check("seq_count", k, 4);
`ifdef MEM_RESPONDER_RR_ARB_EN
        check("seq_order", {28'd0, seq}, 32'h5);
`else
        check("seq_order", {28'd0, seq}, 32'hF);
`endif

        // Zero wait states on instance B.
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h4; b_d_wdata = 32'h44444444;
        step();
        check("ws0_d_ack", b_d_ack, 1);
        b_d_req = 1'b0; b_d_we = 1'b0;
        step();
        check("ws0_idle", b_busy, 0);
        b_i_req = 1'b1; b_i_addr = 32'h4;
        busy_cnt = 0; ack_n = 0; i_rd = '0;
        for (int n = 1; n <= 4; n++) begin
            step();
            if (b_busy) busy_cnt++;
            if (b_i_ack && ack_n == 0) begin ack_n = n; i_rd = b_i_rdata; b_i_req = 1'b0; end
        end
        b_i_req = 1'b0;
        check("ws0_i_lat",   ack_n,    1);
        check("ws0_busy",    busy_cnt, 1);
        check("ws0_i_rdata", i_rd,     32'h44444444);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving extra cycles per access (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_req, input, 1 bit: instruction-fetch request, held high until i_ack.
REQ-006 The block SHALL have port i_addr, input, 32 bits: instruction byte address.
REQ-007 The block SHALL have port i_rdata, output, 32 bits: fetched instruction word.
REQ-008 The block SHALL have port i_ack, output, 1 bit: one-cycle completion pulse for the fetch.
REQ-009 The block SHALL have port d_req, input, 1 bit: data request, held high until d_ack.
REQ-010 The block SHALL have port d_we, input, 1 bit: data write enable, qualified by d_req.
REQ-011 The block SHALL have port d_addr, input, 32 bits: data byte address.
REQ-012 The block SHALL have port d_wdata, input, 32 bits: store data.
REQ-013 The block SHALL have port d_rdata, output, 32 bits: load data.
REQ-014 The block SHALL have port d_ack, output, 1 bit: one-cycle completion pulse for the data access.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port err, output, 1 bit: pulses together with the ack of a faulting access.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, WAIT and RESP.
REQ-018 A request SHALL be accepted only in IDLE. On the accepting edge, address, write enable, write data and port ID SHALL be latched.
REQ-019 After acceptance, the FSM SHALL go IDLE->WAIT when WAIT_STATES>0 and IDLE->RESP when WAIT_STATES=0.
REQ-020 In WAIT, a 4-bit counter loaded with WAIT_STATES-1 SHALL decrement each cycle. The FSM SHALL go to RESP on the cycle after the counter reaches 0.
REQ-021 RESP SHALL last exactly one cycle, assert the granted port's ack, and always return to IDLE.
REQ-022 Ack SHALL therefore be high in the (WAIT_STATES+1)th cycle after the accepting edge.
REQ-023 Read data SHALL be valid on the granted rdata port during its ack cycle and SHALL be held until that port's next ack.
REQ-024 A write SHALL commit to storage on the clock edge that ends the RESP cycle.
REQ-025 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-026 An address with addr[1:0]!=0, or with any bit above the index set, SHALL be a fault: err high with ack, write dropped, read data 0.
REQ-027 The requester SHALL NOT drop req before ack. If req is dropped anyway, the latched transaction SHALL still complete, including its ack and write.
REQ-028 When i_req and d_req are both high in IDLE, d SHALL be granted (fixed priority). The other request stays pending and is accepted on a later IDLE cycle.
REQ-029 The minimum spacing between consecutive accepts SHALL be WAIT_STATES+2 cycles, because RESP always returns through IDLE.
REQ-030 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-031 Assertion of reset (reset=0) SHALL immediately force state IDLE, counter 0, i_ack=0, d_ack=0, err=0, busy=0, i_rdata=0, d_rdata=0, and arbitration pointer favouring d.
REQ-032 Reset during WAIT or RESP SHALL abort the access: no ack and no write.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-034 With macro MEM_RESPONDER_RR_ARB_EN defined, simultaneous requests SHALL be granted round-robin: the pointer toggles after every contested grant, starting with d after reset.
REQ-035 Without MEM_RESPONDER_RR_ARB_EN, arbitration SHALL be fixed d-priority per REQ-028, and no pointer flop SHALL exist.

Structure
REQ-036 Package mem_responder_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the port-ID enum (PORT_I/PORT_D), WORD_BYTES=4 and the counter width.
REQ-037 Storage SHALL be sub-module mem_responder_array: synchronous write, asynchronous read, DEPTH_WORDS x 32.

Verification
REQ-038 The bench SHALL cover: WAIT_STATES=2, d write addr 0x10 data 0xDEADBEEF, then d read 0x10 -> each d_ack 3 cycles after accept, d_rdata=0xDEADBEEF, err=0.
REQ-039 The bench SHALL cover: i_req and d_req (read 0x0) raised in the same cycle -> d_ack first; i_ack exactly WAIT_STATES+2 cycles later; acks never overlap.
REQ-040 The bench SHALL cover: MEM_RESPONDER_RR_ARB_EN with both ports continuously requesting -> grants alternate d,i,d,i.
REQ-041 The bench SHALL cover: d write to 0x13 (misaligned), then to 0x1000 with DEPTH_WORDS=1024 -> err pulses with d_ack each time, storage unchanged.
REQ-042 The bench SHALL cover: reset pulled low during WAIT of a write to 0x20 -> no ack, and a subsequent read of 0x20 returns its prior value.
REQ-043 The bench SHALL cover: WAIT_STATES=0, i read 0x4 -> i_ack in the first cycle after accept, busy high for exactly 1 cycle.
